// File: rtl/spi_serf_pkg.sv
// Shared types and constants for the SPI serf: frame geometry, FSM states
// and the debug snapshot exported by the top.
package spi_serf_pkg;

  localparam int FRAME_BITS = 16;
  localparam int ADDR_W     = 7;
  localparam int DATA_W     = 8;
  localparam int CNT_W      = 5;

  localparam logic [CNT_W-1:0] CNT_FULL = 5'd16;
  localparam logic [CNT_W-1:0] CNT_RD   = 5'd8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  typedef struct packed {
    state_e           state;
    logic [CNT_W-1:0] bit_cnt;
    logic             ss_s;
    logic             sclk_s;
  } dbg_t;

  // Bit counter stops at all-ones so an overlong frame can never wrap back to 16.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous pin plus rise/fall detection.
// All flops preset to 1 so idle-high pins produce no edge after reset.
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   edge_q, edge_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
    edge_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '1;
      edge_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      edge_q <= edge_d;
    end
  end

  assign sync_o = sync_q[SYNC_STAGES-1];
  assign rise_o = sync_o & ~edge_q;
  assign fall_o = ~sync_o & edge_q;

endmodule

// File: rtl/spi_serf.sv
// SPI serf (mode 3, 16-bit frames): decodes read/write register frames from
// an asynchronous monarch and returns read data on MISO within the same frame.
module spi_serf
  import spi_serf_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              SCLK,
  input  logic              MOSI,
  output logic              MISO,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_byte,
  output logic              wr_vld,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              frm_err,
  output dbg_t              dbg
);

  logic ss_s, ss_rise, ss_fall;
  logic sclk_s, sclk_rise, sclk_fall;
  logic mosi_s;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ss_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (SS_n),
    .sync_o   (ss_s),
    .rise_o   (ss_rise),
    .fall_o   (ss_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (SCLK),
    .sync_o   (sclk_s),
    .rise_o   (sclk_rise),
    .fall_o   (sclk_fall)
  );

  // MOSI needs only the level; same depth keeps it aligned with the SCLK edges.
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;

  always_comb mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0]   rx_shft_q, rx_shft_d;
  logic [FRAME_BITS-1:0]   tx_shft_q, tx_shft_d;
  logic                    rd_req_q, rd_req_d;
  logic [ADDR_W-1:0]       rd_addr_q, rd_addr_d;
  logic                    wr_vld_q, wr_vld_d;
  logic [ADDR_W-1:0]       wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]       wr_data_q, wr_data_d;
  logic                    frm_err_q, frm_err_d;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_shft_d = rx_shft_q;
    tx_shft_d = tx_shft_q;
    rd_req_d  = 1'b0;
    rd_addr_d = rd_addr_q;
    wr_vld_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    frm_err_d = 1'b0;

    // Read data lands in the top byte one clk after the request pulse.
    if (rd_req_q) begin
      tx_shft_d[FRAME_BITS-1 -: DATA_W] = rd_byte;
    end

    case (state_q)
      IDLE: begin
        if (ss_fall) begin
          bit_cnt_d = '0;
          tx_shft_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (ss_rise) begin
          state_d = IDLE;
          if (bit_cnt_q == CNT_FULL) begin
            if (!rx_shft_q[FRAME_BITS-1]) begin
              wr_vld_d  = 1'b1;
              wr_addr_d = rx_shft_q[14:8];
              wr_data_d = rx_shft_q[7:0];
            end
          end else begin
            frm_err_d = 1'b1;
          end
        end else begin
          if (sclk_rise) begin
            rx_shft_d = {rx_shft_q[FRAME_BITS-2:0], mosi_s};
            bit_cnt_d = sat_inc(bit_cnt_q);
            // rx_shft_q[6] is the R/W bit after seven shifts.
            if (bit_cnt_q == CNT_RD - 1'b1 && rx_shft_q[6]) begin
              rd_req_d  = 1'b1;
              rd_addr_d = {rx_shft_q[5:0], mosi_s};
            end
          end
          // Hold MISO across the fall after the 8th rise so rd_byte[7] is presented.
          if (sclk_fall && bit_cnt_q != CNT_RD) begin
            tx_shft_d = {tx_shft_q[FRAME_BITS-2:0], 1'b0};
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mosi_sync_q <= '1;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      rx_shft_q   <= '0;
      tx_shft_q   <= '0;
      rd_req_q    <= 1'b0;
      rd_addr_q   <= '0;
      wr_vld_q    <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      frm_err_q   <= 1'b0;
    end else begin
      mosi_sync_q <= mosi_sync_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shft_q   <= rx_shft_d;
      tx_shft_q   <= tx_shft_d;
      rd_req_q    <= rd_req_d;
      rd_addr_q   <= rd_addr_d;
      wr_vld_q    <= wr_vld_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      frm_err_q   <= frm_err_d;
    end
  end

  assign MISO    = ss_s ? 1'bz : tx_shft_q[FRAME_BITS-1];
  assign rd_req  = rd_req_q;
  assign rd_addr = rd_addr_q;
  assign wr_vld  = wr_vld_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign frm_err = frm_err_q;

  always_comb begin
    dbg         = '0;
    dbg.state   = state_q;
    dbg.bit_cnt = bit_cnt_q;
    dbg.ss_s    = ss_s;
    dbg.sclk_s  = sclk_s;
  end

endmodule

// File: tb/tb_spi_serf.sv
// Directed bench for spi_serf: a bit-level SPI monarch drives frames while a
// frame-level model predicts reads, writes, errors, held outputs and MISO idle.
module tb_spi_serf;
  import spi_serf_pkg::*;

  localparam int SYNC = 2;
  localparam int HALF = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              ss_n = 1'b1;
  logic              sclk = 1'b1;
  logic              mosi = 1'b0;
  wire               miso_w;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_byte;
  logic              wr_vld;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              frm_err;
  dbg_t              dbg;

  pullup (miso_w);

  spi_serf #(.SYNC_STAGES(SYNC)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .SS_n    (ss_n),
    .SCLK    (sclk),
    .MOSI    (mosi),
    .MISO    (miso_w),
    .rd_req  (rd_req),
    .rd_addr (rd_addr),
    .rd_byte (rd_byte),
    .wr_vld  (wr_vld),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .frm_err (frm_err),
    .dbg     (dbg)
  );

  // register-file responder
  logic [7:0] resp_mem [128];
  assign rd_byte = resp_mem[rd_addr];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // scoreboard state
  logic [6:0]  exp_rd_q[$];
  logic [14:0] exp_wr_q[$];
  int          exp_err_n   = 0;
  logic [6:0]  hold_addr_m = '0;
  logic [7:0]  hold_data_m = '0;
  int          cyc         = 0;
  int          ss_rise_cyc = 0;
  int          ss_hi_cnt   = 0;
  int          wr_seen     = 0;

  always @(posedge clk) begin
    cyc++;
    if (ss_n) ss_hi_cnt++;
    else ss_hi_cnt = 0;
  end

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      hold_addr_m = '0;
      hold_data_m = '0;
      check("rst_rd_req", rd_req, 0);
      check("rst_wr_vld", wr_vld, 0);
      check("rst_frm_err", frm_err, 0);
      check("rst_rd_addr", rd_addr, 0);
      check("rst_state", dbg.state, IDLE);
      check("rst_bit_cnt", dbg.bit_cnt, 0);
    end else begin
      if (rd_req) begin
        check("rd_req_expected", exp_rd_q.size() > 0, 1);
        if (exp_rd_q.size() > 0) check("rd_addr", rd_addr, exp_rd_q.pop_front());
      end
      if (wr_vld) begin
        wr_seen++;
        check("wr_vld_expected", exp_wr_q.size() > 0, 1);
        if (exp_wr_q.size() > 0) begin
          logic [14:0] e;
          e = exp_wr_q.pop_front();
          hold_addr_m = e[14:8];
          hold_data_m = e[7:0];
        end
        check("wr_latency", cyc - ss_rise_cyc, SYNC + 1);
      end
      if (frm_err) begin
        check("frm_err_expected", exp_err_n > 0, 1);
        if (exp_err_n > 0) exp_err_n--;
        check("err_latency", cyc - ss_rise_cyc, SYNC + 1);
      end
      check("wr_addr_hold", wr_addr, hold_addr_m);
      check("wr_data_hold", wr_data, hold_data_m);
      if (ss_hi_cnt >= SYNC + 1) check("miso_idle_z", miso_w, 1);
    end
  end

  // driver: one frame of nbits; bits beyond 16 are zero
  task automatic spi_frame(input logic [15:0] word, input int nbits, input int lead,
                           output logic [15:0] rx);
    rx = '0;
    if (nbits >= 8 && word[15]) exp_rd_q.push_back(word[14:8]);
    if (nbits == 16 && !word[15]) exp_wr_q.push_back(word[14:0]);
    if (nbits != 16) exp_err_n++;
    @(negedge clk);
    ss_n = 1'b0;
    repeat (lead) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      sclk = 1'b0;
      mosi = (i < 16) ? word[15-i] : 1'b0;
      repeat (HALF) @(negedge clk);
      rx   = {rx[14:0], miso_w};
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
    end
    ss_n = 1'b1;
    ss_rise_cyc = cyc;
    repeat (12) @(negedge clk);
    check("rd_q_drained", exp_rd_q.size(), 0);
    check("wr_q_drained", exp_wr_q.size(), 0);
    check("err_drained", exp_err_n, 0);
  endtask

  task automatic read_frame(input logic [6:0] addr, input int lead, output logic [7:0] data);
    logic [15:0] rx;
    spi_frame({1'b1, addr, 8'h00}, 16, lead, rx);
    check("rd_miso_lead_zero", rx[15:8], 0);
    check("rd_miso_data", rx[7:0], resp_mem[addr]);
    data = rx[7:0];
  endtask

  logic [15:0] rx;
  logic [7:0]  rdat;

  initial begin
    for (int i = 0; i < 128; i++) resp_mem[i] = 8'(i * 29 + 7);
    resp_mem[7'h0F] = 8'h6A;
    resp_mem[7'h22] = 8'h63;
    resp_mem[7'h23] = 8'hCD;

    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    // basic write
    spi_frame(16'h0D02, 16, 4, rx);
    check("w0D02_addr", wr_addr, 7'h0D);
    check("w0D02_data", wr_data, 8'h02);
    check("w0D02_miso", rx, 0);

    // SCLK toggling while deselected is ignored
    for (int i = 0; i < 3; i++) begin
      sclk = 1'b0; repeat (HALF) @(negedge clk);
      sclk = 1'b1; repeat (HALF) @(negedge clk);
    end
    check("idle_state", dbg.state, IDLE);
    check("idle_bit_cnt", dbg.bit_cnt, 16);

    // reads
    read_frame(7'h0F, 4, rdat);
    check("r0F_data", rdat, 8'h6A);
    read_frame(7'h22, 4, rdat);
    check("r22_data", rdat, 8'h63);
    read_frame(7'h23, 4, rdat);
    check("r23_data", rdat, 8'hCD);

    // short write: error, prior write values held
    spi_frame(16'h5577, 9, 4, rx);
    check("short_w_addr", wr_addr, 7'h0D);
    check("short_w_data", wr_data, 8'h02);

    // long write, short read, read with SS_n and first SCLK fall together
    spi_frame(16'h1234, 17, 4, rx);
    spi_frame(16'hC100, 10, 4, rx);
    read_frame(7'h11, 0, rdat);

    spi_frame(16'h7FFF, 16, 3, rx);
    check("w7FFF_addr", wr_addr, 7'h7F);
    check("w7FFF_data", wr_data, 8'hFF);
    spi_frame(16'h0100, 16, 5, rx);
    check("w0100_addr", wr_addr, 7'h01);
    check("w0100_data", wr_data, 8'h00);

    // reset after the 5th rise of a write, then a clean write
    wr_seen = 0;
    ss_n = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      sclk = 1'b0;
      mosi = i[0];
      repeat (HALF) @(negedge clk);
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    ss_n = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("abort_wr_addr", wr_addr, 0);
    spi_frame(16'h2C55, 16, 4, rx);
    check("w2C55_addr", wr_addr, 7'h2C);
    check("w2C55_data", wr_data, 8'h55);
    check("w2C55_count", wr_seen, 1);

    repeat (10) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_serf.md
SPI_SERF -- requirements
Module: spi_serf

Interface
REQ-001 Parameter: SYNC_STAGES, 2, number of metastability flops on SS_n, SCLK and MOSI (legal 2..3).
REQ-002 clk  input  1  system clock; the block has one clock.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 SS_n  input  1  serf select from monarch, active low, asynchronous to clk.
REQ-005 SCLK  input  1  serial clock from monarch, idles high, asynchronous to clk.
REQ-006 MOSI  input  1  serial data from monarch, MSB first.
REQ-007 MISO  output  1  serial data to monarch; high-Z while synchronized SS_n is high.
REQ-008 rd_req  output  1  one-clk pulse requesting register read.
REQ-009 rd_addr  output  7  read address, valid with rd_req.
REQ-010 rd_byte  input  8  read data, sampled the clk after rd_req.
REQ-011 wr_vld  output  1  one-clk pulse, completed write frame.
REQ-012 wr_addr  output  7  write address, valid with wr_vld and held until the next wr_vld.
REQ-013 wr_data  output  8  write data, valid with wr_vld and held until the next wr_vld.
REQ-014 frm_err  output  1  one-clk pulse, frame ended with bit count not equal to 16.

Function
REQ-015 Frame: 16 bits, MSB first; bit15 = R/W (1 = read), bits14:8 = address, bits7:0 = write data (don't-care on read).
REQ-016 SS_n, SCLK and MOSI shall pass through SYNC_STAGES flops plus one edge-detect flop; all three shall have identical delay.
REQ-017 A detected SCLK rise shall shift synchronized MOSI into rx_shft[0] (16-bit, shift left) and increment bit_cnt (5-bit, saturating at 31).
REQ-018 A detected SS_n fall in IDLE shall clear bit_cnt, load tx_shft with 16'h0000 and enter SHIFT.
REQ-019 MISO shall equal tx_shft[15]. Each detected SCLK fall in SHIFT shall shift tx_shft left, except the fall that follows the 8th rise.
REQ-020 On the 8th rise, if the first captured bit is 1, rd_req shall pulse in the same cycle as the bit_cnt update, with rd_addr = rx_shft[6:0] after that shift.
REQ-021 The clk after rd_req, tx_shft[15:8] shall load rd_byte, so rd_byte[7] is on MISO before the 9th rise.
REQ-022 A detected SS_n rise in SHIFT shall return to IDLE. If bit_cnt == 16 and R/W == 0, wr_vld shall pulse with wr_addr = rx_shft[14:8] and wr_data = rx_shft[7:0].
REQ-023 If bit_cnt != 16 at the SS_n rise (short or long frame), frm_err shall pulse and wr_vld shall stay low.
REQ-024 A read frame of exactly 16 bits shall produce neither wr_vld nor frm_err.
REQ-025 States: IDLE (wait for SS_n fall) and SHIFT (count and shift). SCLK edges in IDLE shall be ignored.
REQ-026 Latency: wr_vld/frm_err occur 1 clk after the synchronized SS_n rise is detected, i.e. SYNC_STAGES+1 clk after the pin edge.
REQ-027 An SCLK half-period of at least 8 clk is guaranteed by the monarch. Shorter half-periods are unsupported.
REQ-028 SS_n fall and SCLK edge detected in the same clk: the SS_n action (REQ-018) shall take priority and the SCLK edge shall be dropped.

Reset
REQ-029 On rst_n low at a clk rise, the block shall: enter IDLE; clear bit_cnt, rx_shft and tx_shft; drive rd_req, wr_vld and frm_err to 0; clear wr_addr, wr_data and rd_addr; preset all synchronizer flops to 1.
REQ-030 Reset mid-frame shall abandon the frame without wr_vld or frm_err. A new frame starts only on a later SS_n fall.

Structure
REQ-031 Package spi_serf_pkg shall hold the state enum (IDLE, SHIFT), FRAME_BITS = 16, ADDR_W = 7 and DATA_W = 8.
REQ-032 Sub-module spi_sync_edge (SYNC_STAGES synchronizer plus rise/fall detect outputs) shall be instantiated for SS_n and SCLK. MOSI shall use the same synchronizer depth.

Verification
REQ-033 Write frame 16'h0D02 via SPI_mnrch -> wr_vld pulses once, wr_addr = 7'h0D, wr_data = 8'h02, frm_err = 0.
REQ-034 Read frame 16'h8F00 with the responder returning 8'h6A on rd_addr 7'h0F -> rd_req pulses once after the 8th rise, and the monarch rd_data[7:0] = 8'h6A.
REQ-035 Back-to-back reads 16'hA2xx / 16'hA3xx returning 8'h63 / 8'hCD -> the monarch receives 8'h63 then 8'hCD, with no wr_vld.
REQ-036 SS_n raised after 9 SCLK rises on a write -> frm_err pulses, wr_vld stays 0, and wr_addr/wr_data keep their prior values.
REQ-037 rst_n asserted after the 5th rise of a write, released, then frame 16'h2C55 -> only one wr_vld, with wr_addr = 7'h2C and wr_data = 8'h55.
REQ-038 MISO is high-Z whenever SS_n has been high for at least SYNC_STAGES+1 clk.
